spi_bus_arbiter: RTL

// - Shares the single chameleon2_spi byte engine between three SPI clients: flash loader (0), MMC/SD (1), RTC (2).
// - Grants whole chip-select sessions round-robin and drives all three chip selects.
// - Forwards toggle-handshake byte transfers from the session owner to the engine.
// - Sits between chameleon_spi_flash, the future MMC/RTC controllers and chameleon2_spi.

---
 rtl/spi_bus_arbiter_pkg.sv | 21 ++
 rtl/spi_bus_arbiter_if.sv | 29 ++
 rtl/spi_bus_arbiter_rr_pick3.sv | 21 ++
 rtl/spi_bus_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/spi_bus_arbiter_pkg.sv
// spi_bus_arbiter_pkg: shared state encodings, client indices and round-robin helper
package spi_bus_arbiter_pkg;

    localparam int NUM_CLI   = 3;
    localparam int CLI_FLASH = 0;
    localparam int CLI_MMC   = 1;
    localparam int CLI_RTC   = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_OWN   = 3'd2;
    localparam logic [2:0] ST_XFER  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef logic [1:0] cli_idx_t;

    function automatic cli_idx_t rr_next(input cli_idx_t i);
        return (i >= 2'(NUM_CLI - 1)) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: client and engine handshake signals around the arbiter
interface spi_bus_arbiter_if;

    logic [2:0]  cli_sel;
    logic [2:0]  cli_req;
    logic [2:0]  cli_ack;
    logic [23:0] cli_d;
    logic [2:0]  cli_speed;
    logic [7:0]  cli_q;
    logic [2:0]  grant;
    logic        busy;
    logic [2:0]  cs_out;
    logic        spi_req;
    logic        spi_ack;
    logic [7:0]  spi_d;
    logic [7:0]  spi_q;
    logic        spi_speed;

    modport master (
        input  cli_sel, cli_req, cli_d, cli_speed, spi_ack, spi_q,
        output cli_ack, cli_q, grant, busy, cs_out, spi_req, spi_d, spi_speed
    );

    modport slave (
        output cli_sel, cli_req, cli_d, cli_speed, spi_ack, spi_q,
        input  cli_ack, cli_q, grant, busy, cs_out, spi_req, spi_d, spi_speed
    );

endinterface

// File: rtl/spi_bus_arbiter_rr_pick3.sv
// rr_pick3: combinational round-robin picker, scanning from the client after the last owner
module rr_pick3
    import spi_bus_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    input  cli_idx_t   i_ptr,
    output logic [2:0] o_gnt,
    output cli_idx_t   o_idx
);

    cli_idx_t w_c1;
    cli_idx_t w_c2;
    cli_idx_t w_c3;

    assign w_c1  = rr_next(i_ptr);
    assign w_c2  = rr_next(w_c1);
    assign w_c3  = rr_next(w_c2);
    assign o_idx = i_req[w_c1] ? w_c1 : i_req[w_c2] ? w_c2 : w_c3;
    assign o_gnt = (|i_req) ? 3'b001 << o_idx : 3'b000;

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: grants chip-select sessions round-robin and forwards owner bytes to the SPI engine
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int         CS_SETUP    = 2,
    parameter int         CS_GAP      = 4,
    parameter logic [2:0] CS_ACT_HIGH = 3'b100
) (
    input logic          clk,
    input logic          reset_n,
    spi_bus_arbiter_if.master bus
);

    localparam int MAXC = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
    localparam logic [CW-1:0] SETUP_LD = CW'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
    localparam logic [CW-1:0] GAP_LD   = CW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    cli_idx_t      r_ptr;
    cli_idx_t      r_own;
    logic [2:0]    r_grant;
    logic [2:0]    r_ack;
    logic [7:0]    r_q;
    logic [7:0]    r_spi_d;
    logic          r_spi_req;
    logic          r_spi_speed;
    logic [2:0]    w_gnt;
    cli_idx_t      w_idx;
    logic          w_pend;

    rr_pick3 u_pick (
        .i_req (bus.cli_sel),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_pend = bus.cli_req[r_own] != r_ack[r_own];

    // Session FSM; reset resyncs both toggle pairs so nothing is left pending or in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= 2'd2;
            r_own       <= '0;
            r_grant     <= '0;
            r_ack       <= bus.cli_req;
            r_q         <= '0;
            r_spi_d     <= '0;
            r_spi_req   <= bus.spi_ack;
            r_spi_speed <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (|bus.cli_sel) begin
                    r_grant <= w_gnt;
                    r_own   <= w_idx;
                    r_ptr   <= w_idx;
                    r_cnt   <= SETUP_LD;
                    r_state <= (CS_SETUP == 0) ? ST_OWN : ST_SETUP;
                end
                ST_SETUP: if (r_cnt == '0) r_state <= ST_OWN;
                          else r_cnt <= r_cnt - CW'(1);
                ST_OWN: if (w_pend) begin
                    r_spi_d     <= bus.cli_d[{r_own, 3'b000} +: 8];
                    r_spi_speed <= bus.cli_speed[r_own];
                    r_spi_req   <= ~r_spi_req;
                    r_state     <= ST_XFER;
                end else if (!bus.cli_sel[r_own]) begin
                    r_grant <= '0;
                    r_cnt   <= GAP_LD;
                    r_state <= (CS_GAP == 0) ? ST_IDLE : ST_GAP;
                end
                ST_XFER: if (bus.spi_ack == r_spi_req) begin
                    r_q          <= bus.spi_q;
                    r_ack[r_own] <= ~r_ack[r_own];
                    r_state      <= ST_OWN;
                end
                ST_GAP: if (r_cnt == '0) r_state <= ST_IDLE;
                        else r_cnt <= r_cnt - CW'(1);
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cli_ack   = r_ack;
    assign bus.cli_q     = r_q;
    assign bus.grant     = r_grant;
    assign bus.busy      = r_state != ST_IDLE;
    assign bus.cs_out    = ~(r_grant ^ CS_ACT_HIGH);
    assign bus.spi_req   = r_spi_req;
    assign bus.spi_d     = r_spi_d;
    assign bus.spi_speed = r_spi_speed;

endmodule
